floating_point_mul: RTL and testbench
=====================================

# floating_point_mul

Parametrizable IEEE-754 binary floating-point multiplier with a registered output stage and per-result exception flags. Computes `a × b` with round-to-nearest-even and handles zero, infinity and NaN (quiet and signalling) special cases. It is used as a single-cycle arithmetic unit inside the datapath; the default configuration is binary32.

## Interface
- `EXPONENT_WIDTH`, default 8: exponent field width; bias = 2^(EXPONENT_WIDTH-1) − 1.
- `MANTISSA_WIDTH`, default 23: stored fraction width, excluding the hidden bit.
- Derived `FLOAT_BIT_WIDTH` = EXPONENT_WIDTH + MANTISSA_WIDTH + 1.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `in_valid` input 1: operands on `a`/`b` are valid this cycle.
- `a` input FLOAT_BIT_WIDTH: operand A, fields {sign, exponent, fraction}.
- `b` input FLOAT_BIT_WIDTH: operand B.
- `out_valid` output 1: `out` and the flags hold the result of the operands sampled one cycle earlier.
- `out` output FLOAT_BIT_WIDTH: product.
- `underflow_flag` output 1: result is tiny (below the minimum normal) and inexact.
- `overflow_flag` output 1: the finite product rounded to infinity.
- `invalid_operation_flag` output 1: either operand is an SNaN, or the operation is inf × 0.

## Operation
**Sign.** Result sign = sign(a) XOR sign(b) for every non-NaN result.

**Special-case priority (highest first):**
1. Operand A is an SNaN (exponent all ones, fraction ≠ 0, fraction MSB = 0).
   - `out` = {sign of that operand, all-ones exponent, fraction with only the MSB set}. Example: 0xFFA00000 → 0xFFC00000.
   - Sets invalid.
2. Operand B is an SNaN: same rule as case 1 applied to B.
3. Operand A is a QNaN: passed through unchanged, with no flags. Example: 0xFFC00000 × anything → 0xFFC00000.
4. Operand B is a QNaN: passed through unchanged, with no flags.
5. inf × 0, in either order: `out` = 0x7FC00000 pattern (+, all-ones exponent, fraction MSB set). Sets invalid.
6. Either operand is inf: `out` = signed infinity, with no flags.
7. Either operand is zero: `out` = signed zero, with no flags.

**Finite path.**
- Significand: {hidden, fraction}. The hidden bit is 1 for normals and 0 for subnormals (subnormal exponent treated as 1).
- Multiply into a 2·(MANTISSA_WIDTH+1)-bit product.
- Exponent = eA + eB − bias. Use a signed intermediate at least EXPONENT_WIDTH+3 bits wide.
- Normalize:
  - if the product MSB is set, shift right by 1 and increment the exponent;
  - otherwise left-normalize using leading-zero count, needed for subnormal inputs.
- Round to nearest, ties-to-even, using guard, round and sticky bits. A carry out of rounding renormalizes and increments the exponent.
- Final exponent ≥ all-ones: `out` = signed infinity, overflow = 1.
- Final exponent ≤ 0 (tiny result): handled according to the configuration (see below). Underflow = 1 if the exact result is nonzero and inexact after rounding/flush.
- Flags reflect only the current result; they are not sticky.

## Timing
- One pipeline register stage: latency is exactly 1 cycle; throughput is 1 operation per cycle.
- Each rising edge with `in_valid`=1 captures the computed result:
  - `out` and all three flags load;
  - `out_valid` is 1 in the following cycle.
- `in_valid`=0: `out_valid` goes to 0. `out` and the flags hold their previous values.
- `rst`=1 at an edge:
  - `out`=0, all flags=0, `out_valid`=0;
  - an operation in flight is discarded;
  - reset overrides `in_valid`.
- The first valid result appears 1 cycle after the first `in_valid` edge that follows reset release.
- No backpressure is provided.

## Configuration
- `FPM_SUBNORMAL_EN` defined: full gradual underflow.
  - Subnormal inputs are used at their true value.
  - Tiny results are shifted right into subnormal form (sticky collected) and then rounded with RNE. A round-up may produce the minimum normal.
  - A result that rounds to zero yields signed zero.
- `FPM_SUBNORMAL_EN` undefined: flush-to-zero.
  - Subnormal inputs are treated as signed zero.
  - Any result with final exponent ≤ 0 becomes signed zero with underflow = 1.
- Both modes: 0x00000001 × 0x00000001 → 0x00000000, underflow = 1.

## Test plan
- Reset: assert `rst` for 2 cycles → `out`=0, `out_valid`=0, all flags=0. Release `rst` and present one operation with `in_valid` → `out_valid`=1 exactly 1 cycle later.
- Normal products:
  - 0x40400000 × 0x40800000 → 0x41400000;
  - 0x410B3333 × 0x3E99999A → 0x40270A3E;
  - 0x469C4600 × 0x3DCCCCCD → 0x44FA099A;
  - 0x38D1B717 × 0x3F6E147B → 0x38C308FE;
  - no flags set for any of these.
- Infinity:
  - 0x7F800000 × 0x40400000 → 0x7F800000;
  - 0xFF800000 × 0x7F800000 → 0xFF800000;
  - 0xFF800000 × 0xFF800000 → 0x7F800000;
  - 0x7F800000 × 0x00000000 → 0x7FC00000 with invalid=1.
- NaN:
  - 0xFFC00000 × 0x40800000 → 0xFFC00000, no flags;
  - 0xFFA00000 × 0x40800000 → 0xFFC00000, invalid=1;
  - 0xFFC00000 × 0x00000000 → 0xFFC00000, no flags;
  - 0xFFA00000 × 0x00000000 → 0xFFC00000, invalid=1.
- Zero, overflow and underflow:
  - 0x00000000 × 0x40400000 → 0x00000000;
  - 0x42F00000 × 0x00000000 → 0x00000000;
  - 0x7F000000 × 0x40000000 → 0x7F800000, overflow=1;
  - 0x00000001 × 0x00000001 → 0x00000000, underflow=1.
- Back-to-back operation: apply a new operand pair every cycle → each result appears 1 cycle after its inputs. Deassert `in_valid` → `out_valid`=0 while `out` holds its last value.

Source files
------------

// File: rtl/floating_point_mul.sv
// IEEE-754 binary multiplier (default binary32), round-to-nearest-even, one register stage.
// Define FPM_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module floating_point_mul #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    localparam int FLOAT_BIT_WIDTH = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [FLOAT_BIT_WIDTH-1:0] a,
    input  logic [FLOAT_BIT_WIDTH-1:0] b,
    output logic                       out_valid,
    output logic [FLOAT_BIT_WIDTH-1:0] out,
    output logic                       underflow_flag,
    output logic                       overflow_flag,
    output logic                       invalid_operation_flag
);
    localparam int EW  = EXPONENT_WIDTH;
    localparam int MW  = MANTISSA_WIDTH;
    localparam int FW  = FLOAT_BIT_WIDTH;
    localparam int PW  = 2 * (MW + 1);
    localparam int LZW = $clog2(PW + 1);
    localparam int EI  = EW + LZW + 3;

    localparam logic signed [EI-1:0] BIAS_S = EI'(2 ** (EW - 1) - 1);
    localparam logic signed [EI-1:0] EMAX_S = EI'(2 ** EW - 1);
    localparam logic signed [EI-1:0] ONE_S  = EI'(1);
    localparam logic [LZW-1:0]       LZ_ONE = LZW'(1);
    localparam logic [FW-1:0]        DEFAULT_NAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic          sign_a, sign_b, sign_r;
    logic [EW-1:0] exp_a, exp_b, ea_eff, eb_eff;
    logic [MW-1:0] frac_a, frac_b;

    assign {sign_a, exp_a, frac_a} = a;
    assign {sign_b, exp_b, frac_b} = b;
    assign sign_r = sign_a ^ sign_b;

    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, zero_uf;

    assign a_nan  = (&exp_a) & (|frac_a);
    assign b_nan  = (&exp_b) & (|frac_b);
    assign a_snan = a_nan & ~frac_a[MW-1];
    assign b_snan = b_nan & ~frac_b[MW-1];
    assign a_inf  = (&exp_a) & ~(|frac_a);
    assign b_inf  = (&exp_b) & ~(|frac_b);
`ifdef FPM_SUBNORMAL_EN
    assign a_zero = ~(|exp_a) & ~(|frac_a);
    assign b_zero = ~(|exp_b) & ~(|frac_b);
`else
    assign a_zero = ~(|exp_a);
    assign b_zero = ~(|exp_b);
`endif
    // A zero result from two nonzero encodings means a subnormal was flushed.
    assign zero_uf = (|{exp_a, frac_a}) & (|{exp_b, frac_b});

    // Subnormals carry a hidden 0 and an effective exponent of 1.
    logic [MW:0]   sig_a, sig_b;
    logic [PW-1:0] prod, norm;
    assign sig_a  = {|exp_a, frac_a};
    assign sig_b  = {|exp_b, frac_b};
    assign ea_eff = (|exp_a) ? exp_a : EW'(1);
    assign eb_eff = (|exp_b) ? exp_b : EW'(1);
    assign prod   = {{(MW+1){1'b0}}, sig_a} * {{(MW+1){1'b0}}, sig_b};

    logic [LZW-1:0] lz;
    logic           found;
    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (!found) begin
                if (prod[i]) found = 1'b1;
                else         lz    = lz + LZ_ONE;
            end
        end
    end

    // Leading one lands on the top bit; the exponent absorbs the shift.
    logic signed [EI-1:0] exp_pre;
    assign norm    = prod << lz;
    assign exp_pre = $signed({{(EI-EW){1'b0}}, ea_eff}) + $signed({{(EI-EW){1'b0}}, eb_eff})
                   - BIAS_S + ONE_S - $signed({{(EI-LZW){1'b0}}, lz});

    logic [PW-1:0]        src;
    logic signed [EI-1:0] rnd_exp;
    logic                 extra_sticky;

`ifdef FPM_SUBNORMAL_EN
    logic                 tiny, lost;
    logic signed [EI-1:0] shamt_w;
    logic [LZW-1:0]       sh;
    logic [PW-1:0]        shifted;
    always_comb begin
        tiny    = exp_pre < ONE_S;
        shamt_w = ONE_S - exp_pre;
        sh      = (shamt_w >= EI'(PW)) ? LZW'(PW) : shamt_w[LZW-1:0];
        shifted = norm >> sh;
        lost    = |(norm & ~({PW{1'b1}} << sh));
        // Tiny results denormalize at effective exponent 1.
        src          = tiny ? shifted : norm;
        rnd_exp      = tiny ? ONE_S : exp_pre;
        extra_sticky = tiny & lost;
    end
`else
    always_comb begin
        src          = norm;
        rnd_exp      = exp_pre;
        extra_sticky = 1'b0;
    end
`endif

    logic [MW+1:0]        rounded;
    logic                 guard, sticky, round_up, inexact;
    logic signed [EI-1:0] fin_exp;
    always_comb begin
        guard    = src[MW];
        sticky   = (|src[MW-1:0]) | extra_sticky;
        round_up = guard & (sticky | src[MW+1]);
        inexact  = guard | sticky;
        rounded  = {1'b0, src[PW-1 -: MW+1]} + {{(MW+1){1'b0}}, round_up};
        // Integer part of the rounded significand is 0, 1 or 2 (carry).
        fin_exp  = rnd_exp + $signed({{(EI-2){1'b0}}, rounded[MW+1:MW]}) - ONE_S;
    end

    logic [FW-1:0] res;
    logic          res_uf, res_of, res_inv;
    always_comb begin
        res     = '0;
        res_uf  = 1'b0;
        res_of  = 1'b0;
        res_inv = 1'b0;
        if (a_snan) begin
            res     = {sign_a, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
            res_inv = 1'b1;
        end else if (b_snan) begin
            res     = {sign_b, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
            res_inv = 1'b1;
        end else if (a_nan) begin
            res = a;
        end else if (b_nan) begin
            res = b;
        end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
            res     = DEFAULT_NAN;
            res_inv = 1'b1;
        end else if (a_inf | b_inf) begin
            res = {sign_r, {EW{1'b1}}, {MW{1'b0}}};
        end else if (a_zero | b_zero) begin
            res    = {sign_r, {(FW-1){1'b0}}};
            res_uf = zero_uf;
        end else if (fin_exp >= EMAX_S) begin
            res    = {sign_r, {EW{1'b1}}, {MW{1'b0}}};
            res_of = 1'b1;
`ifdef FPM_SUBNORMAL_EN
        end else begin
            res    = {sign_r, fin_exp[EW-1:0], rounded[MW-1:0]};
            res_uf = tiny & inexact;
        end
`else
        end else if (fin_exp < ONE_S) begin
            res    = {sign_r, {(FW-1){1'b0}}};
            res_uf = 1'b1;
        end else begin
            res = {sign_r, fin_exp[EW-1:0], rounded[MW-1:0]};
        end
`endif
    end

    // Valid-only handshake: every in_valid cycle is accepted (no ready); out_valid
    // follows one cycle later, and out/flags hold their value while in_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid              <= 1'b0;
            out                    <= '0;
            underflow_flag         <= 1'b0;
            overflow_flag          <= 1'b0;
            invalid_operation_flag <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out                    <= res;
                underflow_flag         <= res_uf;
                overflow_flag          <= res_of;
                invalid_operation_flag <= res_inv;
            end
        end
    end
endmodule

// File: tb/tb_floating_point_mul.sv
// Directed-vector bench for floating_point_mul (binary32): reset, special cases,
// rounding, overflow/underflow, back-to-back issue and hold behaviour.
module tb_floating_point_mul;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] out;
    logic        underflow_flag;
    logic        overflow_flag;
    logic        invalid_operation_flag;
    logic [2:0]  flags;

    int checks = 0;
    int errors = 0;

    logic [34:0] exp_q[$];

    floating_point_mul dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_valid               (in_valid),
        .a                      (a),
        .b                      (b),
        .out_valid              (out_valid),
        .out                    (out),
        .underflow_flag         (underflow_flag),
        .overflow_flag          (overflow_flag),
        .invalid_operation_flag (invalid_operation_flag)
    );

    assign flags = {underflow_flag, overflow_flag, invalid_operation_flag};

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags encoded {underflow, overflow, invalid}
    localparam int N = 22;
    logic [31:0] va   [N] = '{
        32'h40400000, 32'h410B3333, 32'h469C4600, 32'h38D1B717,
        32'h7F800000, 32'hFF800000, 32'hFF800000, 32'h7F800000,
        32'hFFC00000, 32'hFFA00000, 32'hFFC00000, 32'hFFA00000,
        32'h00000000, 32'h42F00000, 32'h7F000000, 32'h00000001,
        32'h3FC00000, 32'hC0400000, 32'h40800000, 32'hFFA00000,
        32'h40400000, 32'h00000000};
    logic [31:0] vb   [N] = '{
        32'h40800000, 32'h3E99999A, 32'h3DCCCCCD, 32'h3F6E147B,
        32'h40400000, 32'h7F800000, 32'hFF800000, 32'h00000000,
        32'h40800000, 32'h40800000, 32'h00000000, 32'h00000000,
        32'h40400000, 32'h00000000, 32'h40000000, 32'h00000001,
        32'h3FC00000, 32'h40800000, 32'h7FA00000, 32'h7FC00000,
        32'h7FC00001, 32'h80000000};
    logic [31:0] vout [N] = '{
        32'h41400000, 32'h40270A3E, 32'h44FA099A, 32'h38C308FE,
        32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h7FC00000,
        32'hFFC00000, 32'hFFC00000, 32'hFFC00000, 32'hFFC00000,
        32'h00000000, 32'h00000000, 32'h7F800000, 32'h00000000,
        32'h40100000, 32'hC1400000, 32'h7FC00000, 32'hFFC00000,
        32'h7FC00001, 32'h80000000};
    logic [2:0]  vflg [N] = '{
        3'b000, 3'b000, 3'b000, 3'b000,
        3'b000, 3'b000, 3'b000, 3'b001,
        3'b000, 3'b001, 3'b000, 3'b001,
        3'b000, 3'b000, 3'b010, 3'b100,
        3'b000, 3'b000, 3'b001, 3'b001,
        3'b000, 3'b000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // driver tasks
    task automatic drive_op(input logic [31:0] op_a, input logic [31:0] op_b,
                            input logic [31:0] want_out, input logic [2:0] want_flg);
        in_valid = 1'b1;
        a        = op_a;
        b        = op_b;
        exp_q.push_back({want_flg, want_out});
    endtask

    task automatic check_result(input int idx);
        logic [34:0] e;
        e = exp_q.pop_front();
        check($sformatf("v%0d_valid", idx), {31'b0, out_valid}, 32'd1);
        check($sformatf("v%0d_out", idx), out, e[31:0]);
        check($sformatf("v%0d_flags", idx), {29'b0, flags}, {29'b0, e[34:32]});
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h40400000;
        b        = 32'h40800000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out", out, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_flags", {29'b0, flags}, 32'd0);

        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_valid", {31'b0, out_valid}, 32'd0);

        // single operation after reset: result one cycle later
        drive_op(va[0], vb[0], vout[0], vflg[0]);
        @(negedge clk);
        in_valid = 1'b0;
        check_result(100);
        @(negedge clk);
        check("single_drop_valid", {31'b0, out_valid}, 32'd0);

        // back-to-back: a new pair every cycle
        for (int i = 0; i < N; i++) begin
            drive_op(va[i], vb[i], vout[i], vflg[i]);
            @(negedge clk);
            check_result(i);
        end
        in_valid = 1'b0;
        a        = 32'h3F800000;
        b        = 32'h3F800000;
        @(negedge clk);
        check("hold_valid", {31'b0, out_valid}, 32'd0);
        check("hold_out", out, vout[N-1]);
        check("hold_flags", {29'b0, flags}, {29'b0, vflg[N-1]});
        @(negedge clk);
        check("hold2_out", out, vout[N-1]);

        // reset overrides an operation presented in the same cycle
        drive_op(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010);
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(negedge clk);
        check("rst2_out", out, 32'h0);
        check("rst2_valid", {31'b0, out_valid}, 32'd0);
        check("rst2_flags", {29'b0, flags}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst2_idle_valid", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
